// File: rtl/l_inv_stage_if.sv
// Load/enable/ready handshake and data bus of the inverse L stage.
interface l_inv_stage_if #(
    parameter int W = 128
);
    logic         enable;
    logic         load;
    logic [W-1:0] DI;
    logic [W-1:0] DO;
    logic         ready;

    modport master (output enable, output load, output DI, input DO, input ready);
    modport slave  (input enable, input load, input DI, output DO, output ready);
endinterface

// File: rtl/l_inv_stage.sv
// Iterative Kuznyechik inverse linear transform: one R^-1 round per enabled
// clock over a 128-bit block, ROUNDS rounds per transform.
module l_inv_stage #(
    parameter int W      = 128,
    parameter int ROUNDS = 16
) (
    input  logic          clk,
    input  logic          rst,
    l_inv_stage_if.slave  bus
);
    localparam int CW = $clog2(ROUNDS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Coefficient of c_k lives in byte k (c15 in the top byte).
    localparam logic [127:0] LCOEF = 128'h94_20_85_10_C2_C0_01_FB_01_C0_C2_10_85_20_94_01;

    logic [1:0]    fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_q, data_d;
    logic          ready_q, ready_d;
    logic [W-1:0]  rinv;
    logic [7:0]    lsum;

    // Multiply by x modulo x^8+x^7+x^6+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'hC3 : 8'h00);
    endfunction

    // Constant-coefficient multiply; k is a constant so this folds to XORs.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc ^= p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // One R^-1 round: shift bytes up, new low byte is l(a14..a0, a15).
    always_comb begin
        lsum = gmul(data_q[W-1 -: 8], LCOEF[7:0]);
        for (int k = 1; k < 16; k++) begin
            lsum ^= gmul(data_q[8*(k-1) +: 8], LCOEF[8*k +: 8]);
        end
        rinv = {data_q[W-9:0], lsum};
    end

    // Next-state logic; load overrides everything except reset.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ready_d = ready_q;
        if (bus.load) begin
            fsm_d   = S_RUN;
            cnt_d   = '0;
            data_d  = bus.DI;
            ready_d = 1'b0;
        end else if (fsm_q == S_RUN && bus.enable) begin
            data_d = rinv;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == CW'(ROUNDS)) begin
                fsm_d   = S_DONE;
                ready_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    assign bus.DO    = data_q;
    assign bus.ready = ready_q;
endmodule
